// File: rtl/piece_queue.sv
// piece_queue: next-piece buffer downstream of the shape randomiser.
//
// Samples the free-running 3-bit shape_id into a shift-register FIFO of
// upcoming tetromino IDs (0..6). The game FSM pops the head with take. All
// queued entries are exposed on preview_ids, with the head at bits [2:0].
//
// Optional feature: define PQ_NO_REPEAT_EN to reject samples that repeat the
// last pushed piece. After MAX_REROLL consecutive rejections, the next legal
// sample is accepted even if it repeats.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high; clears the queue
//   shape_id     candidate piece from randomiser (7 is illegal)
//   take         single-cycle pop request
//   piece_valid  queue non-empty
//   piece_id     head entry, 0 when empty
//   preview_ids  entry k at [3k+2:3k], k=0 is head; unused slots read 0
//   count        occupancy 0..DEPTH
//   bad_seen     sticky: shape_id==7 sampled since reset
//   issued       number of successful pops, wraps at 16 bits
module piece_queue #(
    parameter int DEPTH      = 3,
    parameter int CNT_W      = 4,
    parameter int MAX_REROLL = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [2:0]           shape_id,
    input  logic                 take,
    output logic                 piece_valid,
    output logic [2:0]           piece_id,
    output logic [3*DEPTH-1:0]   preview_ids,
    output logic [CNT_W-1:0]     count,
    output logic                 bad_seen,
    output logic [15:0]          issued
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILLING,
        ST_FULL
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_t                 state, state_nxt;
    logic [DEPTH-1:0][2:0]  slots, slots_nxt;
    logic [CNT_W-1:0]       count_nxt;
    logic [CNT_W-1:0]       wr_idx;
    logic                   accept;
    logic                   legal;
    logic                   do_push;
    logic                   do_pop;

    assign legal   = (shape_id != 3'd7);
    assign do_pop  = take && (state != ST_EMPTY);
    // Push is gated on the pre-edge state, so a full queue with take only pops.
    assign do_push = (state != ST_FULL) && legal && accept;

`ifdef PQ_NO_REPEAT_EN
    localparam int RR_W = (MAX_REROLL < 1) ? 1 : $clog2(MAX_REROLL + 1);

    logic [2:0]      last_pushed;
    logic [RR_W-1:0] reroll_cnt;

    // last_pushed resets to 7 ("none") so the first legal sample never
    // matches.
    assign accept = (shape_id != last_pushed) ||
                    (reroll_cnt == RR_W'(MAX_REROLL));

    always_ff @(posedge clock) begin
        if (reset) begin
            last_pushed <= 3'd7;
            reroll_cnt  <= '0;
        end else if (do_push) begin
            last_pushed <= shape_id;
            reroll_cnt  <= '0;
        end else if (legal && (state != ST_FULL) && !accept) begin
            reroll_cnt  <= reroll_cnt + RR_W'(1);
        end
    end
`else
    assign accept = 1'b1;
`endif

    // Next-state and occupancy
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
        case (state)
            ST_EMPTY:
                if (do_push) state_nxt = ST_FILLING;
            ST_FILLING:
                if (do_push && !do_pop && (count == DEPTH_C - CNT_W'(1)))
                    state_nxt = ST_FULL;
                else if (do_pop && !do_push && (count == CNT_W'(1)))
                    state_nxt = ST_EMPTY;
            ST_FULL:
                if (do_pop) state_nxt = ST_FILLING;
            default:
                state_nxt = ST_EMPTY;
        endcase
    end

    // Storage: shift down on pop, then write the new tail. When a push and a
    // pop happen together, the tail sits one slot lower after the shift.
    assign wr_idx = do_pop ? (count - CNT_W'(1)) : count;

    always_comb begin
        slots_nxt = slots;
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++)
                slots_nxt[i] = slots[i+1];
            slots_nxt[DEPTH-1] = 3'd0;
        end
        for (int i = 0; i < DEPTH; i++)
            if (do_push && (wr_idx == CNT_W'(i)))
                slots_nxt[i] = shape_id;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_EMPTY;
            slots    <= '0;
            count    <= '0;
            bad_seen <= 1'b0;
            issued   <= 16'd0;
        end else begin
            state <= state_nxt;
            slots <= slots_nxt;
            count <= count_nxt;
            if (!legal)
                bad_seen <= 1'b1;
            if (do_pop)
                issued <= issued + 16'd1;
        end
    end

    // Slots above the tail are always zero, so the raw storage is the preview.
    assign piece_valid = (state != ST_EMPTY);
    assign piece_id    = slots[0];
    assign preview_ids = slots;

endmodule

// File: tb/tb_piece_queue.sv
// Testbench for piece_queue: directed checks with literal expectations,
// followed by randomized stimulus checked every cycle against a queue-based
// reference model.
module tb_piece_queue;
    localparam int DEPTH      = 3;
    localparam int CNT_W      = 4;
    localparam int MAX_REROLL = 3;

    logic                 clock;
    logic                 reset;
    logic [2:0]           shape_id;
    logic                 take;
    logic                 piece_valid;
    logic [2:0]           piece_id;
    logic [3*DEPTH-1:0]   preview_ids;
    logic [CNT_W-1:0]     count;
    logic                 bad_seen;
    logic [15:0]          issued;

    piece_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_REROLL(MAX_REROLL)) dut (
        .clock(clock), .reset(reset), .shape_id(shape_id), .take(take),
        .piece_valid(piece_valid), .piece_id(piece_id),
        .preview_ids(preview_ids), .count(count), .bad_seen(bad_seen),
        .issued(issued)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model
    int       mq[$];
    bit       m_bad;
    int       m_iss;
    int       m_last;
    int       m_rr;

    always @(posedge clock) begin
        bit pop, push, full, acc;
        if (reset) begin
            mq.delete();
            m_bad  = 1'b0;
            m_iss  = 0;
            m_last = 7;
            m_rr   = 0;
        end else begin
            full = (mq.size() == DEPTH);
            pop  = take && (mq.size() > 0);
`ifdef PQ_NO_REPEAT_EN
            acc = (int'(shape_id) != m_last) || (m_rr == MAX_REROLL);
`else
            acc = 1'b1;
`endif
            push = !full && (shape_id != 3'd7) && acc;
            if (shape_id == 3'd7) m_bad = 1'b1;
            if (pop) begin
                void'(mq.pop_front());
                m_iss = (m_iss + 1) % 65536;
            end
            if (push) begin
                mq.push_back(int'(shape_id));
                m_last = int'(shape_id);
                m_rr   = 0;
            end else if (!full && (shape_id != 3'd7)) begin
                m_rr++;
            end
        end
    end

    // Compare process: every negedge once reset has been applied
    always @(negedge clock) begin
        if (chk_en) begin
            logic [3*DEPTH-1:0] exp_prev;
            exp_prev = '0;
            for (int k = 0; k < mq.size(); k++)
                exp_prev[3*k +: 3] = 3'(mq[k]);
            chk("model.count",   32'(count),       32'(mq.size()));
            chk("model.valid",   32'(piece_valid), 32'(mq.size() != 0));
            chk("model.head",    32'(piece_id),    32'(mq.size() != 0 ? mq[0] : 0));
            chk("model.preview", 32'(preview_ids), 32'(exp_prev));
            chk("model.bad",     32'(bad_seen),    32'(m_bad));
            chk("model.issued",  32'(issued),      32'(m_iss));
        end
    end

    task automatic tick(input int sid, input bit tk, input bit rst);
        shape_id = 3'(sid);
        take     = tk;
        reset    = rst;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        shape_id = 3'd0;
        take     = 1'b0;
        reset    = 1'b1;
        tick(0, 0, 1);
        chk_en = 1'b1;
        tick(0, 0, 1);
        chk("rst.valid",   32'(piece_valid), 32'd0);
        chk("rst.count",   32'(count),       32'd0);
        chk("rst.preview", 32'(preview_ids), 32'd0);
        chk("rst.bad",     32'(bad_seen),    32'd0);
        chk("rst.issued",  32'(issued),      32'd0);

        // Fill with 2,5,1; fourth sample is dropped
        tick(2, 0, 0);
        chk("first.valid", 32'(piece_valid), 32'd1);
        tick(5, 0, 0);
        tick(1, 0, 0);
        chk("fill.count",   32'(count),       32'd3);
        chk("fill.head",    32'(piece_id),    32'd2);
        chk("fill.preview", 32'(preview_ids), 32'(9'b001_101_010));
        tick(4, 0, 0);
        chk("full.drop",    32'(preview_ids), 32'(9'b001_101_010));

        // Full with take: pop only, refill next edge
        tick(6, 1, 0);
        chk("fullpop.count",  32'(count),    32'd2);
        chk("fullpop.head",   32'(piece_id), 32'd5);
        chk("fullpop.issued", 32'(issued),   32'd1);
        tick(6, 0, 0);
        chk("refill.preview", 32'(preview_ids), 32'(9'b110_001_101));
        chk("refill.count",   32'(count),       32'd3);

        // Simultaneous push and pop at count=1
        tick(0, 0, 1);
        tick(3, 0, 0);
        chk("one.head", 32'(piece_id), 32'd3);
        tick(4, 1, 0);
        chk("pp.count",  32'(count),    32'd1);
        chk("pp.head",   32'(piece_id), 32'd4);
        chk("pp.issued", 32'(issued),   32'd1);

        // Empty + take + illegal sample
        tick(0, 0, 1);
        tick(7, 1, 0);
        chk("bad.valid",  32'(piece_valid), 32'd0);
        chk("bad.count",  32'(count),       32'd0);
        chk("bad.issued", 32'(issued),      32'd0);
        chk("bad.sticky", 32'(bad_seen),    32'd1);
        tick(2, 0, 0);
        chk("bad.hold",   32'(bad_seen),    32'd1);
        tick(5, 0, 0);
        chk("pre_rst.count", 32'(count), 32'd2);

        // Reset mid-operation with take
        tick(3, 1, 1);
        chk("midrst.count",  32'(count),       32'd0);
        chk("midrst.issued", 32'(issued),      32'd0);
        chk("midrst.bad",    32'(bad_seen),    32'd0);
        chk("midrst.prev",   32'(preview_ids), 32'd0);
        tick(3, 0, 0);
        chk("postrst.count", 32'(count),    32'd1);
        chk("postrst.head",  32'(piece_id), 32'd3);

        // Repeat handling
        tick(4, 0, 0);
        chk("rep.base", 32'(count), 32'd2);
        tick(4, 0, 0);
`ifdef PQ_NO_REPEAT_EN
        chk("rep.first", 32'(count), 32'd2);
`else
        chk("rep.first", 32'(count), 32'd3);
`endif
        tick(4, 0, 0);
        tick(4, 0, 0);
        tick(4, 0, 0);
        chk("rep.fourth", 32'(count), 32'd3);

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            tick($urandom_range(0, 7), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 80) == 0));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/piece_queue.md
Name: piece_queue

Overview:
- Next-piece buffer sitting directly downstream of the shape randomiser.
- Samples the randomiser's free-running 3-bit shape_id and holds a FIFO of upcoming tetromino IDs (0..6).
- The game-control FSM pops the head when spawning a new piece.
- Exposes all queued entries as a flat preview bus for the "next pieces" display.

Parameters:
- DEPTH, 3, number of queued pieces (legal 2..8).
- CNT_W, 4, width of occupancy counter; must hold 0..DEPTH.
- MAX_REROLL, 3, consecutive rejected samples tolerated before a repeat is force-accepted (used only with PQ_NO_REPEAT_EN).

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears queue.
- shape_id  input  3  candidate piece from randomiser; changes every cycle; legal 0..6.
- take  input  1  single-cycle pop request from game FSM.
- piece_valid  output  1  head entry valid (queue non-empty).
- piece_id  output  3  head entry (oldest); 3'd0 when empty.
- preview_ids  output  3*DEPTH  entry k at bits [3k+2:3k], k=0 is head; unused slots read 3'd0.
- count  output  CNT_W  current occupancy 0..DEPTH.
- bad_seen  output  1  sticky: shape_id==7 was sampled since reset.
- issued  output  16  number of successful pops, wraps 16'hFFFF->0.

Behaviour:
- One clock; reset is synchronous and active-high, sampled on rising clock edge; ports named clock and reset.
- Reset values:
  - piece_valid=0, piece_id=0, preview_ids all 0, count=0, bad_seen=0, issued=0.
  - All storage slots cleared to 0.
  - Reroll counter=0.
  - last-pushed register=3'd7 (means "none").
- Reset asserted mid-operation discards all queued pieces on that edge; no pop is counted that cycle even if take=1.
- Storage: shift-register FIFO, head at slot 0. A pop shifts slots down by one; the vacated top slot becomes 0.
- Push condition, evaluated on the pre-edge state: count < DEPTH AND shape_id != 7 AND the reroll rule accepts.
  - A push writes shape_id into slot count, or into slot count-1 if a pop occurs the same cycle.
- Pop condition: take=1 AND count != 0. take while empty is ignored; issued does not change.
- Simultaneous push and pop: both occur; count unchanged; the new entry lands at the tail after the shift.
- Full with take: pop only (push gated by pre-edge count==DEPTH); count becomes DEPTH-1; refill on the following edge if the sample is legal.
- shape_id==7 while not full: no push; bad_seen set to 1 (sticky until reset); count unchanged.
- Latency:
  - First legal sample lands on the first rising edge with reset low; piece_valid rises after that edge.
  - Queue is full DEPTH edges after reset release, given legal non-rejected samples.
- Outputs are registered or derived directly from registers; no combinational path from take or shape_id to any output.
- count saturates structurally at DEPTH and never exceeds it. A pop at count=0 never underflows.
- issued increments by exactly 1 per pop; 16-bit natural wrap.
- FSM, encoded from count:
  - EMPTY (count=0): piece_valid=0; push-only.
  - FILLING (0<count<DEPTH): push and/or pop.
  - FULL (count=DEPTH): pop-only.
- Transitions:
  - EMPTY->FILLING on push.
  - FILLING->FULL on push without pop at count=DEPTH-1.
  - FILLING->EMPTY on pop without push at count=1.
  - FULL->FILLING on pop.

Optional Feature:
- Macro PQ_NO_REPEAT_EN.
- Defined:
  - A legal sample equal to the last-pushed register is rejected: no push, and the reroll counter increments.
  - When the reroll counter equals MAX_REROLL, the next legal sample is accepted even if it repeats.
  - Any push clears the reroll counter and updates last-pushed.
  - Pops do not alter last-pushed.
- Not defined: reroll logic absent; every legal sample pushes when not full; last-pushed and reroll registers are not synthesised.

Test Plan:
- Reset then shape_id sequence 2,5,1 on three edges with take=0 -> count=3, piece_valid=1, piece_id=2, preview_ids=9'b001_101_010; a fourth sample 4 is not stored.
- Full queue {2,5,1}, take=1 one cycle, shape_id=6 -> next edge count=2, piece_id=5, issued=1; following edge queue {5,1,6}, count=3.
- count=1 (head 3), take=1 with shape_id=4 same cycle -> count stays 1, piece_id=4, issued increments by 1.
- Empty queue, take=1 while shape_id=7 -> piece_valid=0, count=0, issued=0, bad_seen=1; bad_seen holds through later legal pushes until reset.
- Queue at count=2, assert reset for one edge with take=1 -> all outputs return to reset values; issued=0; next edge with shape_id=3 gives count=1, piece_id=3.
- With PQ_NO_REPEAT_EN, after pushing 4, hold shape_id=4 -> rejected for 3 edges, accepted on the 4th (count +1); without the macro, accepted on the first edge.
